// File: rtl/ccu_ctrl_snoop_collector.sv
// Collects per-port ACE snoop responses (CR/CD) for one coherent transaction and forwards the
// first data responder's line to R (and to writeback if dirty). Option: CCU_SNOOP_CD_LAST_CHECK_EN.

module ccu_ctrl_snoop_collector_port (
  input  logic       collect_i,
  input  logic       pending_i,
  input  logic       cr_valid_i,
  input  logic [4:0] cr_resp_i,
  output logic       cr_ready_o,
  output logic       hs_o,
  output logic       data_o,
  output logic       err_o,
  output logic       dirty_o,
  output logic       shared_o
);
  logic unused_was_unique;

  assign cr_ready_o        = collect_i & pending_i;
  assign hs_o              = cr_ready_o & cr_valid_i;
  assign data_o            = hs_o & cr_resp_i[0];
  assign err_o             = hs_o & cr_resp_i[1];
  assign dirty_o           = hs_o & cr_resp_i[2];
  assign shared_o          = hs_o & cr_resp_i[3];
  assign unused_was_unique = cr_resp_i[4];
endmodule

module ccu_ctrl_snoop_collector #(
  parameter int  NoMstPorts      = 4,
  parameter int  DcacheLineWidth = 128,
  parameter int  AxiDataWidth    = 64,
  localparam int LineBeats       = DcacheLineWidth / AxiDataWidth,
  localparam int IdxW            = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               snoop_start_i,
  input  logic [NoMstPorts-1:0]              snoop_mask_i,
  output logic                               busy_o,
  input  logic [NoMstPorts-1:0]              cr_valid_i,
  output logic [NoMstPorts-1:0]              cr_ready_o,
  input  logic [NoMstPorts*5-1:0]            cr_resp_i,
  input  logic [NoMstPorts-1:0]              cd_valid_i,
  output logic [NoMstPorts-1:0]              cd_ready_o,
  input  logic [NoMstPorts*AxiDataWidth-1:0] cd_data_i,
  input  logic [NoMstPorts-1:0]              cd_last_i,
  output logic [AxiDataWidth-1:0]            r_data_o,
  output logic                               r_last_o,
  output logic                               r_valid_o,
  input  logic                               r_ready_i,
  output logic [AxiDataWidth-1:0]            cd_o,
  output logic                               cd_handshake_o,
  input  logic                               cd_fifo_full_i,
  output logic [IdxW-1:0]                    first_responder_o,
  output logic                               resp_valid_o,
  input  logic                               resp_ready_i,
  output logic                               resp_data_o,
  output logic                               resp_dirty_o,
  output logic                               resp_shared_o,
  output logic                               resp_error_o
);
  localparam int CntW = $clog2(LineBeats) + 1;

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_STREAM, S_DRAIN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [NoMstPorts-1:0] pending_q, pending_d;
  logic [NoMstPorts-1:0] data_mask_q, data_mask_d;
  logic [IdxW-1:0]       fr_q, fr_d;
  logic                  fr_valid_q, fr_valid_d;
  logic                  dirty_q, dirty_d;
  logic                  shared_q, shared_d;
  logic                  error_q, error_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [NoMstPorts-1:0] cr_hs, cr_data, cr_err, cr_dirty, cr_shared;
  logic [NoMstPorts-1:0] last_seen;
  logic                  last_en;
  logic                  collect, at_last, sink_ok, beat;
  logic [IdxW-1:0]       drain_idx;

  function automatic logic [IdxW-1:0] lowest_idx(input logic [NoMstPorts-1:0] v);
    logic [IdxW-1:0] r;
    r = '0;
    for (int i = NoMstPorts - 1; i >= 0; i--) begin
      if (v[i]) r = IdxW'(i);
    end
    return r;
  endfunction

  assign collect = (state_q == S_COLLECT);

  for (genvar i = 0; i < NoMstPorts; i++) begin : g_port
    ccu_ctrl_snoop_collector_port u_port (
      .collect_i  (collect),
      .pending_i  (pending_q[i]),
      .cr_valid_i (cr_valid_i[i]),
      .cr_resp_i  (cr_resp_i[i*5 +: 5]),
      .cr_ready_o (cr_ready_o[i]),
      .hs_o       (cr_hs[i]),
      .data_o     (cr_data[i]),
      .err_o      (cr_err[i]),
      .dirty_o    (cr_dirty[i]),
      .shared_o   (cr_shared[i])
    );
  end

`ifdef CCU_SNOOP_CD_LAST_CHECK_EN
  assign last_en   = 1'b1;
  assign last_seen = cd_last_i;
`else
  logic [NoMstPorts-1:0] unused_cd_last;
  assign unused_cd_last = cd_last_i;
  assign last_en        = 1'b0;
  assign last_seen      = '0;
`endif

  // Beat count alone terminates a line; cd_last_i is at most a consistency check.
  assign at_last   = (cnt_q == CntW'(LineBeats - 1));
  assign sink_ok   = !dirty_q || !cd_fifo_full_i;
  assign drain_idx = lowest_idx(data_mask_q);

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    data_mask_d    = data_mask_q;
    fr_d           = fr_q;
    fr_valid_d     = fr_valid_q;
    dirty_d        = dirty_q;
    shared_d       = shared_q;
    error_d        = error_q;
    cnt_d          = cnt_q;
    cd_ready_o     = '0;
    r_valid_o      = 1'b0;
    r_last_o       = 1'b0;
    cd_handshake_o = 1'b0;
    resp_valid_o   = 1'b0;
    beat           = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (snoop_start_i) begin
          pending_d   = snoop_mask_i;
          data_mask_d = '0;
          fr_d        = '0;
          fr_valid_d  = 1'b0;
          dirty_d     = 1'b0;
          shared_d    = 1'b0;
          error_d     = 1'b0;
          cnt_d       = '0;
          state_d     = (|snoop_mask_i) ? S_COLLECT : S_DONE;
        end
      end
      S_COLLECT: begin
        pending_d   = pending_q & ~cr_hs;
        data_mask_d = data_mask_q | cr_data;
        error_d     = error_q | (|cr_err);
        dirty_d     = dirty_q | (|cr_dirty);
        shared_d    = shared_q | (|cr_shared);
        // Earliest cycle wins; ties within a cycle go to the lowest port.
        if (!fr_valid_q && (|cr_data)) begin
          fr_d       = lowest_idx(cr_data);
          fr_valid_d = 1'b1;
        end
        if (pending_d == '0) state_d = (data_mask_d != '0) ? S_STREAM : S_DONE;
      end
      S_STREAM: begin
        cd_ready_o[fr_q] = r_ready_i && sink_ok;
        r_valid_o        = cd_valid_i[fr_q] && sink_ok;
        r_last_o         = at_last;
        beat             = cd_valid_i[fr_q] && r_ready_i && sink_ok;
        cd_handshake_o   = beat && dirty_q;
        if (beat) begin
          if (last_en && (last_seen[fr_q] != at_last)) error_d = 1'b1;
          if (at_last) begin
            cnt_d             = '0;
            data_mask_d[fr_q] = 1'b0;
            state_d           = (data_mask_d != '0) ? S_DRAIN : S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        cd_ready_o[drain_idx] = 1'b1;
        if (cd_valid_i[drain_idx]) begin
          if (last_en && (last_seen[drain_idx] != at_last)) error_d = 1'b1;
          if (at_last) begin
            cnt_d                  = '0;
            data_mask_d[drain_idx] = 1'b0;
            if (data_mask_d == '0) state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      data_mask_q <= '0;
      fr_q        <= '0;
      fr_valid_q  <= 1'b0;
      dirty_q     <= 1'b0;
      shared_q    <= 1'b0;
      error_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      data_mask_q <= data_mask_d;
      fr_q        <= fr_d;
      fr_valid_q  <= fr_valid_d;
      dirty_q     <= dirty_d;
      shared_q    <= shared_d;
      error_q     <= error_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy_o            = (state_q != S_IDLE);
  assign first_responder_o = fr_q;
  assign r_data_o          = cd_data_i[int'(fr_q)*AxiDataWidth +: AxiDataWidth];
  assign cd_o              = r_data_o;
  assign resp_data_o       = (state_q == S_DONE) && fr_valid_q;
  assign resp_dirty_o      = (state_q == S_DONE) && dirty_q;
  assign resp_shared_o     = (state_q == S_DONE) && shared_q;
  assign resp_error_o      = (state_q == S_DONE) && error_q;
endmodule

// File: tb/tb_ccu_ctrl_snoop_collector.sv
// Randomized bench for ccu_ctrl_snoop_collector: transaction-level model predicts responder,
// flags, stream/drain order and per-cycle handshakes.

module tb_ccu_ctrl_snoop_collector;
  localparam int N  = 4;
  localparam int LW = 128;
  localparam int DW = 64;
  localparam int LB = LW / DW;
  localparam int IW = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            snoop_start_i;
  logic [N-1:0]    snoop_mask_i;
  logic            busy_o;
  logic [N-1:0]    cr_valid_i, cr_ready_o;
  logic [N*5-1:0]  cr_resp_i;
  logic [N-1:0]    cd_valid_i, cd_ready_o, cd_last_i;
  logic [N*DW-1:0] cd_data_i;
  logic [DW-1:0]   r_data_o, cd_o;
  logic            r_last_o, r_valid_o, r_ready_i;
  logic            cd_handshake_o, cd_fifo_full_i;
  logic [IW-1:0]   first_responder_o;
  logic            resp_valid_o, resp_ready_i, resp_data_o, resp_dirty_o, resp_shared_o, resp_error_o;

  always #5 clk_i = ~clk_i;

  ccu_ctrl_snoop_collector #(.NoMstPorts(N), .DcacheLineWidth(LW), .AxiDataWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .snoop_start_i(snoop_start_i), .snoop_mask_i(snoop_mask_i), .busy_o(busy_o),
    .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
    .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i), .cd_last_i(cd_last_i),
    .r_data_o(r_data_o), .r_last_o(r_last_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .cd_o(cd_o), .cd_handshake_o(cd_handshake_o), .cd_fifo_full_i(cd_fifo_full_i),
    .first_responder_o(first_responder_o),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
    .resp_dirty_o(resp_dirty_o), .resp_shared_o(resp_shared_o), .resp_error_o(resp_error_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction description
  logic [N-1:0]  t_mask, t_bad;
  logic [4:0]    t_resp [N];
  int            t_dly  [N];
  int            t_stall, t_abort, t_pin_f, t_pin_err, t_pin_cyc;
  logic [DW-1:0] line [N][LB];

  task automatic clr_setup();
    t_mask = '0; t_bad = '0; t_stall = 0; t_abort = 0;
    t_pin_f = -1; t_pin_err = -1; t_pin_cyc = -1;
    for (int p = 0; p < N; p++) begin t_resp[p] = '0; t_dly[p] = 0; end
  endtask

  task automatic rand_setup();
    clr_setup();
    t_mask = N'($urandom_range(0, 15));
    for (int p = 0; p < N; p++) begin
      t_resp[p]    = 5'($urandom);
      t_resp[p][0] = ($urandom_range(0, 2) != 0);
      t_dly[p]     = $urandom_range(0, 3);
      t_bad[p]     = ($urandom_range(0, 4) == 0);
    end
  endtask

  task automatic run_txn();
    logic [N-1:0]  dports, hs_done, exp_cdr;
    int            idx [N];
    int            rcnt, pushes, best, stall_left, first_done, dp;
    logic [IW-1:0] exp_f;
    logic          exp_data, exp_dirty, exp_shared, exp_err;
    logic          coll_done, in_stream, in_drain, in_done, sink, fin, aborted;

    // Model: earliest data responder wins, lowest index on ties; flags are ORs.
    exp_f = '0; exp_data = 0; exp_dirty = 0; exp_shared = 0; exp_err = 0; best = 1000;
    for (int p = 0; p < N; p++) begin
      for (int b = 0; b < LB; b++) line[p][b] = {$urandom, $urandom};
      idx[p]    = 0;
      dports[p] = t_mask[p] & t_resp[p][0];
      if (t_mask[p]) begin
        exp_err    |= t_resp[p][1];
        exp_dirty  |= t_resp[p][2];
        exp_shared |= t_resp[p][3];
        if (t_resp[p][0]) begin
          exp_data = 1'b1;
          if (t_dly[p] < best) begin best = t_dly[p]; exp_f = IW'(p); end
`ifdef CCU_SNOOP_CD_LAST_CHECK_EN
          if (t_bad[p]) exp_err = 1'b1;
`endif
        end
      end
    end

    @(negedge clk_i);
    snoop_start_i = 1'b1; snoop_mask_i = t_mask;
    cr_valid_i = '0; cd_valid_i = '0; r_ready_i = 0; resp_ready_i = 0; cd_fifo_full_i = 0;
    #1;
    chk("idle_busy", busy_o, 0);
    chk("idle_cr_ready", cr_ready_o, 0);

    hs_done = '0; rcnt = 0; pushes = 0; stall_left = 3; first_done = -1; fin = 0; aborted = 0;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clk_i);
      snoop_start_i = 1'b0;
      snoop_mask_i  = N'($urandom);

      if (t_abort != 0 && rcnt == 1) begin
        r_ready_i = 1'b1; cd_valid_i = '1; resp_ready_i = 1'b1; rst_ni = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_cr_ready", cr_ready_o, 0);
        chk("rst_cd_ready", cd_ready_o, 0);
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_r_last", r_last_o, 0);
        chk("rst_cd_push", cd_handshake_o, 0);
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_fr", first_responder_o, 0);
        @(negedge clk_i);
        cd_valid_i = '0; cr_valid_i = '0; r_ready_i = 0; resp_ready_i = 0; rst_ni = 1'b1;
        aborted = 1;
        break;
      end

      coll_done = ((t_mask & ~hs_done) == '0);
      in_stream = coll_done && exp_data && (rcnt < LB);
      dp = -1;
      if (coll_done && exp_data && rcnt == LB)
        for (int p = N - 1; p >= 0; p--) if (dports[p] && idx[p] < LB) dp = p;
      in_drain = (dp >= 0);
      in_done  = coll_done && !in_stream && !in_drain;

      for (int p = 0; p < N; p++) begin
        cr_valid_i[p] = t_mask[p] && !hs_done[p] && (cyc - 1 >= t_dly[p]);
        cr_resp_i[p*5 +: 5] = cr_valid_i[p] ? t_resp[p] : 5'($urandom);
        cd_valid_i[p] = dports[p] && (idx[p] < LB) && (t_stall != 0 || $urandom_range(0, 3) != 0);
        if (idx[p] < LB) cd_data_i[p*DW +: DW] = line[p][idx[p]];
        else             cd_data_i[p*DW +: DW] = {$urandom, $urandom};
        cd_last_i[p] = t_bad[p] ? (idx[p] == 0) : (idx[p] == LB - 1);
      end
      if (t_stall != 0) begin
        r_ready_i      = 1'b1;
        cd_fifo_full_i = (rcnt == 1 && stall_left > 0);
        if (cd_fifo_full_i) stall_left--;
      end else begin
        r_ready_i      = ($urandom_range(0, 3) != 0);
        cd_fifo_full_i = ($urandom_range(0, 3) == 0);
      end
      resp_ready_i = 1'($urandom_range(0, 1));
      #1;

      chk("busy", busy_o, 1);
      chk("cr_ready", cr_ready_o, t_mask & ~hs_done);
      sink    = !exp_dirty || !cd_fifo_full_i;
      exp_cdr = '0;
      if (in_stream) exp_cdr[exp_f] = r_ready_i && sink;
      if (in_drain)  exp_cdr[dp]    = 1'b1;
      chk("cd_ready", cd_ready_o, exp_cdr);
      chk("r_valid", r_valid_o, in_stream && cd_valid_i[exp_f] && sink);
      chk("cd_push", cd_handshake_o, in_stream && cd_valid_i[exp_f] && r_ready_i && sink && exp_dirty);
      if (in_stream && r_valid_o && r_ready_i) begin
        chk("r_data", r_data_o, line[exp_f][rcnt]);
        chk("r_last", r_last_o, rcnt == LB - 1);
        chk("fr_stream", first_responder_o, exp_f);
        if (cd_handshake_o) begin
          chk("cd_data", cd_o, line[exp_f][rcnt]);
          pushes++;
        end
        rcnt++;
      end
      chk("resp_valid", resp_valid_o, in_done);
      if (in_done) begin
        if (first_done < 0) first_done = cyc;
        chk("resp_data", resp_data_o, exp_data);
        chk("resp_dirty", resp_dirty_o, exp_dirty);
        chk("resp_shared", resp_shared_o, exp_shared);
        chk("resp_error", resp_error_o, exp_err);
        chk("resp_fr", first_responder_o, exp_data ? exp_f : '0);
        if (resp_ready_i) begin
          fin = 1;
          chk("r_beats", rcnt, exp_data ? LB : 0);
          chk("cd_pushes", pushes, (exp_data && exp_dirty) ? LB : 0);
          for (int p = 0; p < N; p++) chk("cd_consumed", idx[p], dports[p] ? LB : 0);
          if (t_pin_f >= 0)   chk("pin_fr", first_responder_o, t_pin_f);
          if (t_pin_err >= 0) chk("pin_err", resp_error_o, t_pin_err);
          if (t_pin_cyc >= 0) chk("pin_resp_cycle", first_done, t_pin_cyc);
        end
      end

      for (int p = 0; p < N; p++) begin
        if (cr_valid_i[p] && cr_ready_o[p]) hs_done[p] = 1'b1;
        if (cd_valid_i[p] && cd_ready_o[p]) idx[p]++;
      end
    end

    if (!fin && !aborted) begin
      chk("timeout", 0, 1);
      @(negedge clk_i);
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
    end
  endtask

  initial begin
    rst_ni = 1'b0; snoop_start_i = 0; snoop_mask_i = '0;
    cr_valid_i = '0; cr_resp_i = '0; cd_valid_i = '0; cd_last_i = '0;
    cd_data_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    r_ready_i = 0; cd_fifo_full_i = 0; resp_ready_i = 0;
    #1;
    chk("reset_busy", busy_o, 0);
    chk("reset_cr_ready", cr_ready_o, 0);
    chk("reset_cd_ready", cd_ready_o, 0);
    chk("reset_r_valid", r_valid_o, 0);
    chk("reset_r_last", r_last_o, 0);
    chk("reset_cd_push", cd_handshake_o, 0);
    chk("reset_resp_valid", resp_valid_o, 0);
    chk("reset_resp_flags", {resp_data_o, resp_dirty_o, resp_shared_o, resp_error_o}, 0);
    chk("reset_fr", first_responder_o, 0);
    chk("reset_r_data", r_data_o, cd_data_i[DW-1:0]);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Empty mask: summary one cycle after start, all flags clear
    clr_setup(); t_pin_cyc = 1; t_pin_err = 0;
    run_txn();
    // All CRs in first collect cycle, no data: summary two cycles after start
    clr_setup(); t_mask = 4'b1111;
    for (int p = 0; p < N; p++) t_resp[p] = 5'b01000;
    t_pin_cyc = 2;
    run_txn();
    // Same-cycle CRs, port 2 dirty data, port 1 shared
    clr_setup(); t_mask = 4'b0110; t_resp[2] = 5'b00101; t_resp[1] = 5'b01000; t_pin_f = 2;
    run_txn();
    // Port 3 answers first with data, port 1 later and is drained
    clr_setup(); t_mask = 4'b1010; t_resp[1] = 5'b00001; t_dly[1] = 1; t_resp[3] = 5'b00001; t_pin_f = 3;
    run_txn();
    // Dirty stream stalled 3 cycles mid-line by a full CD FIFO
    clr_setup(); t_mask = 4'b0001; t_resp[0] = 5'b00101; t_stall = 1; t_pin_f = 0;
    run_txn();
    // cd_last on beat 0
    clr_setup(); t_mask = 4'b0100; t_resp[2] = 5'b00001; t_bad[2] = 1'b1;
`ifdef CCU_SNOOP_CD_LAST_CHECK_EN
    t_pin_err = 1;
`else
    t_pin_err = 0;
`endif
    run_txn();
    // Reset during stream, then a fresh transaction
    clr_setup(); t_mask = 4'b0011; t_resp[0] = 5'b00001; t_resp[1] = 5'b00001; t_abort = 1;
    run_txn();
    clr_setup(); t_mask = 4'b0011; t_resp[0] = 5'b00001; t_resp[1] = 5'b00101; t_pin_f = 0;
    run_txn();

    for (int k = 0; k < 80; k++) begin
      rand_setup();
      run_txn();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
